ptmch_trg_sched: RTL and testbench

Schedules the five instruction-match trigger pulses from the SPI flash command detector onto one shared external trigger line.
- Latches each incoming pulse as a pending request and grants requests round-robin.
- For each grant, emits one fixed-width TRG_OUT pulse tagged with the channel ID, then enforces a holdoff gap before the next grant.
- Keeps a saturating event counter and a sticky overflow flag per channel for host readback.
- TRG_IN comes from logic on CLK160M, so no input synchronisers are required.

---
 rtl/ptmch_trg_sched.sv | 193 +++++++++++++++++++
 tb/tb_ptmch_trg_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ptmch_trg_sched.sv
// ptmch_trg_sched
// Merges the per-channel instruction-match trigger pulses onto one shared
// external trigger line. Each accepted rising edge is held as a pending
// request. Pending requests are granted round-robin. Every grant produces one
// fixed-width TRG_OUT pulse tagged with TRG_ID, followed by a holdoff gap.
// Each channel also has a saturating event counter and a sticky overflow flag.
//
// Ports:
//   CLK160M  - system clock
//   RESET_N  - synchronous active-low reset
//   TRG_IN   - per-channel trigger pulses (already in the CLK160M domain)
//   CH_EN    - per-channel enable; a disabled channel also drops its pending request
//   CLR_CNT  - single-cycle clear of EVT_CNT and OVF
//   TRG_OUT  - scheduled trigger pulse, P_PLS_LEN clocks wide
//   TRG_ID   - channel index of the current or last granted pulse
//   BUSY     - scheduler is in PULSE or HOLDOFF
//   OVF      - sticky: an edge arrived while that channel was already pending
//   EVT_CNT  - accepted-edge counters; channel i at [i*P_CNT_W +: P_CNT_W]
module ptmch_trg_sched #(
  parameter int unsigned P_CH      = 5,
  parameter int unsigned P_PLS_LEN = 16,
  parameter int unsigned P_HOLDOFF = 64,
  parameter int unsigned P_CNT_W   = 16
) (
  input  logic                      CLK160M,
  input  logic                      RESET_N,
  input  logic [P_CH-1:0]           TRG_IN,
  input  logic [P_CH-1:0]           CH_EN,
  input  logic                      CLR_CNT,
  output logic                      TRG_OUT,
  output logic [2:0]                TRG_ID,
  output logic                      BUSY,
  output logic [P_CH-1:0]           OVF,
  output logic [P_CH*P_CNT_W-1:0]   EVT_CNT
);

  localparam int unsigned LP_TMAX    = (P_PLS_LEN > P_HOLDOFF) ? P_PLS_LEN : P_HOLDOFF;
  localparam int unsigned LP_TW      = (LP_TMAX < 2) ? 1 : $clog2(LP_TMAX);
  localparam int unsigned LP_PL_LOAD = P_PLS_LEN - 1;
  localparam int unsigned LP_HO_LOAD = (P_HOLDOFF > 0) ? P_HOLDOFF - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HOLDOFF
  } state_t;

  state_t                         r_state, w_state_nxt;
  logic [LP_TW-1:0]               r_tmr, w_tmr_nxt;
  logic [2:0]                     r_rr, w_rr_nxt;
  logic [2:0]                     r_id, w_id_nxt;
  logic                           r_out, w_out_nxt;
  logic [P_CH-1:0]                r_in_d;
  logic [P_CH-1:0]                r_pend;
  logic [P_CH-1:0]                r_ovf;
  logic [P_CH-1:0][P_CNT_W-1:0]   r_cnt;

  logic [P_CH-1:0]                w_rise;
  logic [P_CH-1:0]                w_acc;
  logic [P_CH-1:0]                w_sel;
  logic [P_CH-1:0]                w_grant;
  logic [2:0]                     w_sel_idx;
  logic                           w_found;

  assign w_rise = TRG_IN & ~r_in_d;
  assign w_acc  = w_rise & CH_EN;

  // Round-robin search. The outer loop walks the search distance
  // 1..P_CH starting after r_rr. The inner loop finds the channel at that
  // distance. The first pending channel found wins.
  always_comb begin
    w_sel     = '0;
    w_sel_idx = '0;
    w_found   = 1'b0;
    for (int unsigned off = 1; off <= P_CH; off++) begin
      for (int unsigned i = 0; i < P_CH; i++) begin
        if (!w_found && r_pend[i] && (i == ((32'(r_rr) + off) % P_CH))) begin
          w_found   = 1'b1;
          w_sel[i]  = 1'b1;
          w_sel_idx = 3'(i);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_rr_nxt    = r_rr;
    w_id_nxt    = r_id;
    w_out_nxt   = r_out;
    w_grant     = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_grant     = w_sel;
          w_state_nxt = ST_PULSE;
          w_tmr_nxt   = LP_TW'(LP_PL_LOAD);
          w_rr_nxt    = w_sel_idx;
          w_id_nxt    = w_sel_idx;
          w_out_nxt   = 1'b1;
        end
      end
      ST_PULSE: begin
        if (r_tmr == '0) begin
          w_out_nxt = 1'b0;
          if (P_HOLDOFF == 0) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_HOLDOFF;
            w_tmr_nxt   = LP_TW'(LP_HO_LOAD);
          end
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      ST_HOLDOFF: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tmr_nxt = r_tmr - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK160M) begin
    if (!RESET_N) begin
      r_state <= ST_IDLE;
      r_tmr   <= '0;
      r_rr    <= 3'(P_CH - 1);
      r_id    <= '0;
      r_out   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tmr   <= w_tmr_nxt;
      r_rr    <= w_rr_nxt;
      r_id    <= w_id_nxt;
      r_out   <= w_out_nxt;
    end
  end

  // Pending requests. A disabled channel drops its request. An accepted
  // edge has priority over a grant of the same channel, so the request
  // survives the grant.
  always_ff @(posedge CLK160M) begin
    if (!RESET_N) begin
      r_in_d <= '0;
      r_pend <= '0;
    end else begin
      r_in_d <= TRG_IN;
      for (int unsigned i = 0; i < P_CH; i++) begin
        if (!CH_EN[i]) begin
          r_pend[i] <= 1'b0;
        end else if (w_acc[i]) begin
          r_pend[i] <= 1'b1;
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLK160M) begin
    if (!RESET_N) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else if (CLR_CNT) begin
      r_cnt <= '0;
      r_ovf <= '0;
    end else begin
      for (int unsigned i = 0; i < P_CH; i++) begin
        if (w_acc[i] && (r_cnt[i] != '1)) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
        if (w_acc[i] && r_pend[i] && !w_grant[i]) begin
          r_ovf[i] <= 1'b1;
        end
      end
    end
  end

  assign TRG_OUT = r_out;
  assign TRG_ID  = r_id;
  assign BUSY    = (r_state != ST_IDLE);
  assign OVF     = r_ovf;
  assign EVT_CNT = r_cnt;

endmodule

// File: tb/tb_ptmch_trg_sched.sv
// Directed bench for ptmch_trg_sched. Instance u_a uses the default
// parameters. Instance u_b has zero holdoff.
module tb_ptmch_trg_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  trg_a, trg_b, ch_en;
  logic        clr;
  logic        a_out, a_busy, b_out, b_busy;
  logic [2:0]  a_id, b_id;
  logic [4:0]  a_ovf, b_ovf;
  logic [79:0] a_cnt, b_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int a_t[$], a_ids[$], b_t[$], b_ids[$];
  int b_hi  = 0;
  logic a_prev = 1'b0, b_prev = 1'b0;

  always #5 clk = ~clk;

  ptmch_trg_sched u_a (
    .CLK160M(clk), .RESET_N(rst_n), .TRG_IN(trg_a), .CH_EN(ch_en), .CLR_CNT(clr),
    .TRG_OUT(a_out), .TRG_ID(a_id), .BUSY(a_busy), .OVF(a_ovf), .EVT_CNT(a_cnt)
  );

  ptmch_trg_sched #(.P_HOLDOFF(0)) u_b (
    .CLK160M(clk), .RESET_N(rst_n), .TRG_IN(trg_b), .CH_EN(ch_en), .CLR_CNT(clr),
    .TRG_OUT(b_out), .TRG_ID(b_id), .BUSY(b_busy), .OVF(b_ovf), .EVT_CNT(b_cnt)
  );

  // Record every TRG_OUT rising edge with its cycle number and TRG_ID.
  always @(negedge clk) begin
    cyc++;
    if (a_out && !a_prev) begin a_t.push_back(cyc); a_ids.push_back(int'(a_id)); end
    if (b_out && !b_prev) begin b_t.push_back(cyc); b_ids.push_back(int'(b_id)); end
    if (b_out) b_hi++;
    a_prev = a_out;
    b_prev = b_out;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] cnt_of(input logic [79:0] v, input int i);
    return v[i*16 +: 16];
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trg_a = '0; trg_b = '0; clr = 1'b0;
    step(2);
    rst_n = 1'b1;
    a_t.delete(); a_ids.delete(); b_t.delete(); b_ids.delete(); b_hi = 0;
  endtask

  initial begin
    int hi, busy;
    ch_en = 5'h1F;
    do_reset();

    // Reset state
    chk("rst_out",  a_out, 0);
    chk("rst_id",   a_id, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ovf",  a_ovf, 0);
    chk("rst_cnt",  a_cnt, 0);

    // Single pulse on channel 3: latency, width, busy length
    trg_a = 5'h08;
    step();                       // sampling edge k
    chk("lat_k_out", a_out, 0);
    trg_a = '0;
    step();                       // edge k+1
    chk("lat_k1_out", a_out, 1);
    chk("t2_id", a_id, 3);
    chk("t2_cnt3", cnt_of(a_cnt, 3), 1);
    hi = 0; busy = 0;
    for (int c = 0; c < 200 && a_busy; c++) begin
      hi += int'(a_out);
      busy++;
      step();
    end
    chk("t2_width", hi, 16);
    chk("t2_busy", busy, 80);
    chk("t2_idle_out", a_out, 0);
    chk("t2_id_hold", a_id, 3);

    // All five channels at once: round-robin order and spacing
    do_reset();
    trg_a = 5'h1F;
    step();
    trg_a = '0;
    step(450);
    chk("t3_ngrant", a_t.size(), 5);
    for (int i = 0; i < a_t.size() && i < 5; i++) begin
      chk($sformatf("t3_id%0d", i), a_ids[i], i);
      if (i > 0) chk($sformatf("t3_gap%0d", i), a_t[i] - a_t[i-1], 81);
      chk($sformatf("t3_cnt%0d", i), cnt_of(a_cnt, i), 1);
    end
    chk("t3_ovf", a_ovf, 0);

    // Overflow on channel 2 while pending through a holdoff
    do_reset();
    for (int c = 0; c < 300; c++) begin
      case (c)
        0:      trg_a = 5'h01;
        3:      trg_a = 5'h04;
        30, 50: trg_a = 5'h04;
        default: trg_a = 5'h00;
      endcase
      step();
    end
    chk("t4_ngrant", a_t.size(), 2);
    if (a_ids.size() == 2) chk("t4_id1", a_ids[1], 2);
    chk("t4_ovf", a_ovf, 5'b00100);
    chk("t4_cnt2", cnt_of(a_cnt, 2), 3);
    chk("t4_cnt0", cnt_of(a_cnt, 0), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("t4_clr_ovf", a_ovf, 0);
    chk("t4_clr_cnt", a_cnt, 0);

    // Disabled channel ignores edges
    do_reset();
    ch_en = 5'h1D;
    trg_a = 5'h02;
    step();
    trg_a = '0;
    step(100);
    chk("t5_nogrant", a_t.size(), 0);
    chk("t5_cnt1", cnt_of(a_cnt, 1), 0);

    // Disabling a pending channel drops its request
    ch_en = 5'h1F;
    for (int c = 0; c < 250; c++) begin
      case (c)
        0: trg_a = 5'h01;
        3: trg_a = 5'h02;
        default: trg_a = 5'h00;
      endcase
      if (c == 40) ch_en = 5'h1D;
      if (c == 45) ch_en = 5'h1F;
      step();
    end
    chk("t5_drop_n", a_t.size(), 1);
    chk("t5_drop_cnt1", cnt_of(a_cnt, 1), 1);

    // Zero holdoff: a level held high is a single edge
    do_reset();
    for (int c = 0; c < 160; c++) begin
      trg_b = (c < 100) ? 5'h01 : 5'h00;
      step();
    end
    chk("t6_ngrant", b_t.size(), 1);
    chk("t6_width", b_hi, 16);
    chk("t6_cnt0", cnt_of(b_cnt, 0), 1);
    // Zero holdoff back-to-back: rr continues after channel 0, spacing 17
    b_t.delete(); b_ids.delete();
    trg_b = 5'h03;
    step();
    trg_b = '0;
    step(60);
    chk("t6_n2", b_t.size(), 2);
    if (b_t.size() == 2) begin
      chk("t6_id0", b_ids[0], 1);
      chk("t6_id1", b_ids[1], 0);
      chk("t6_gap", b_t[1] - b_t[0], 17);
    end

    // Reset during the pulse aborts and loses the pending request
    do_reset();
    trg_a = 5'h08;
    step();                       // edge k
    trg_a = 5'h02;
    step();                       // edge k+1: grant ch3, pend ch1
    trg_a = '0;
    chk("t7_pulse", a_out, 1);
    step(3);                      // after pulse clock 4
    rst_n = 1'b0;
    step();                       // pulse clock 5 edge in reset
    chk("t7_out", a_out, 0);
    chk("t7_busy", a_busy, 0);
    chk("t7_id", a_id, 0);
    chk("t7_cnt", a_cnt, 0);
    rst_n = 1'b1;
    a_t.delete(); a_ids.delete();
    step(100);
    chk("t7_lost", a_t.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
